mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-requester arbiter sharing the single-port data ram between port A (nbbpu data port) and port B
//  (loader/DMA/debug master). Grants one access per cycle, drives the ram, and returns read data to the
//  requester that issued the read one cycle later. Sits between the requesters and ram inside nbbsoc.
// PARAMETERS
//  ADDR_W     16  address width, all ports
//  DATA_W     16  data width, all ports
//  MAX_BURST  4   max consecutive grants to one owner while the other requests (>=1)
// PORTS
//  clock             in   1       system clock, all logic rising-edge
//  reset             in   1       synchronous, active-high
//  a_req             in   1       A requests an access this cycle
//  a_we              in   1       A access is a write (1) / read (0)
//  a_addr            in   ADDR_W  A address
//  a_wdata           in   DATA_W  A write data
//  a_gnt             out  1       A access accepted this cycle (combinational)
//  a_rvalid          out  1       A read data valid (1 cycle after granted read)
//  a_rdata           out  DATA_W  A read data
//  b_req/b_we/b_addr/b_wdata/b_gnt/b_rvalid/b_rdata   same as A, for port B
//  ram_read_enable   out  1       to ram read_enable
//  ram_write_enable  out  1       to ram write_enable
//  ram_address       out  ADDR_W  to ram address
//  ram_write_data    out  DATA_W  to ram write_data
//  ram_read_data     in   DATA_W  from ram; valid 1 cycle after ram_read_enable
//  owner             out  2       00 none, 01 A, 10 B (current-cycle grant; debug/blink)
// BEHAVIOUR
//  - Reset: state IDLE, burst_cnt 0, last_owner=B, a/b_rvalid 0, a/b_rdata 0; a_gnt, b_gnt,
//    ram_*_enable forced 0 and owner 00 while reset high. Reset mid-read drops the pending return.
//  - FSM (registered = owner of previous cycle): IDLE, OWN_A, OWN_B.
//    Grant decision each cycle, combinational from req + state + burst_cnt:
//      only A req -> A; only B req -> B; neither -> none (next state IDLE, burst_cnt 0).
//      both req: if state=OWN_x and burst_cnt<MAX_BURST -> x keeps grant (no preemption mid-burst);
//                if state=OWN_x and burst_cnt==MAX_BURST -> other side;
//                if state=IDLE -> tie rule (see CONFIGURATION).
//    Next state = OWN_<winner>; burst_cnt = 1 on owner change, +1 on same owner (saturates at MAX_BURST).
//  - gnt never asserted without matching req; at most one of a_gnt/b_gnt high.
//  - Granted cycle: ram_address/ram_write_data = winner's addr/wdata; ram_write_enable = winner we;
//    ram_read_enable = !winner we. No grant: enables 0, address/write_data 0.
//  - Read return: rd_owner register captures winner of a granted read; next cycle that port's rvalid=1
//    and rdata=ram_read_data (registered 1-cycle latency total = 1 after gnt). Other port rvalid 0,
//    rdata holds last value. Writes produce no rvalid. Back-to-back reads: one return per cycle, in order.
//  - Requester must hold req/we/addr/wdata stable until gnt; dropping req before gnt is legal (no access).
//  - MAX_BURST=1: strict alternation under continuous contention.
//  - burst_cnt width = $clog2(MAX_BURST+1); no wrap (saturates).
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN
//   defined:   IDLE tie -> requester != last_owner (last_owner updated on every grant); first contended
//              access after reset goes to A.
//   undefined: IDLE tie -> A always (fixed priority); last_owner register not built. Burst limit applies
//              in both builds, so B is never starved beyond MAX_BURST cycles.
// TESTING
//  1 reset held 3 cycles with a_req=b_req=1 -> a_gnt=b_gnt=0, enables 0, rvalid 0, owner 00.
//  2 A read addr 0x0010 (ram holds 0xBEEF), B idle -> a_gnt same cycle, next cycle a_rvalid=1,
//    a_rdata=0xBEEF, b_rvalid=0.
//  3 A and B req continuously, MAX_BURST=4 -> grant pattern A,A,A,A,B,B,B,B,A... ; none lost.
//  4 B write 0x1234 to 0x0020, then A read 0x0020 next cycle -> a_rdata=0x1234 one cycle after a_gnt.
//  5 reset asserted cycle after granted B read -> b_rvalid stays 0; after release state IDLE, burst_cnt 0.
//  6 both req from IDLE twice (idle gap between): RR build -> A then B; fixed build -> A then A.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter with burst-limited ownership and 1-cycle read return.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: round-robin IDLE tie-break (default: fixed priority to A).
module mem_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [1:0]        owner
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [1:0]         rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0]  a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]  b_rdata_q, b_rdata_d;
  logic               grant_a, grant_b;
  logic               burst_done;
  logic               tie_to_a;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_owner: 0 = A, 1 = B
  logic last_owner_q, last_owner_d;
  assign tie_to_a = last_owner_q;

  always_comb begin
    last_owner_d = last_owner_q;
    if (grant_a) last_owner_d = 1'b0;
    if (grant_b) last_owner_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) last_owner_q <= 1'b1;
    else       last_owner_q <= last_owner_d;
  end
`else
  assign tie_to_a = 1'b1;
`endif

  // Grant decision: current owner keeps the RAM under contention until its burst is used up.
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    burst_done = (burst_cnt_q >= CNT_W'(MAX_BURST));
    if (!reset) begin
      if (a_req && !b_req) begin
        grant_a = 1'b1;
      end else if (b_req && !a_req) begin
        grant_b = 1'b1;
      end else if (a_req && b_req) begin
        case (state_q)
          OWN_A: begin
            grant_a = !burst_done;
            grant_b = burst_done;
          end
          OWN_B: begin
            grant_a = burst_done;
            grant_b = !burst_done;
          end
          default: begin
            grant_a = tie_to_a;
            grant_b = !tie_to_a;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d     = IDLE;
    burst_cnt_d = '0;
    if (grant_a) begin
      state_d = OWN_A;
      if (state_q != OWN_A) burst_cnt_d = CNT_W'(1);
      else if (burst_done)  burst_cnt_d = burst_cnt_q;
      else                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end else if (grant_b) begin
      state_d = OWN_B;
      if (state_q != OWN_B) burst_cnt_d = CNT_W'(1);
      else if (burst_done)  burst_cnt_d = burst_cnt_q;
      else                  burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end

    rd_owner_d = {grant_b && !b_we, grant_a && !a_we};

    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (rd_owner_q[0]) a_rdata_d = ram_read_data;
    if (rd_owner_q[1]) b_rdata_d = ram_read_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      rd_owner_q  <= 2'b00;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      rd_owner_q  <= rd_owner_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;
  assign owner = {grant_b, grant_a};

  // RAM drive: winner's request, all zero when nobody is granted.
  always_comb begin
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    ram_address      = '0;
    ram_write_data   = '0;
    if (grant_a) begin
      ram_read_enable  = !a_we;
      ram_write_enable = a_we;
      ram_address      = a_addr;
      ram_write_data   = a_wdata;
    end else if (grant_b) begin
      ram_read_enable  = !b_we;
      ram_write_enable = b_we;
      ram_address      = b_addr;
      ram_write_data   = b_wdata;
    end
  end

  // Return path: RAM data arrives the cycle after the grant, so it is forwarded straight out.
  assign a_rvalid = rd_owner_q[0] && !reset;
  assign b_rvalid = rd_owner_q[1] && !reset;
  assign a_rdata  = a_rvalid ? ram_read_data : a_rdata_q;
  assign b_rdata  = b_rvalid ? ram_read_data : b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [15:0] a_rdata, b_rdata;
  logic        ram_read_enable, ram_write_enable;
  logic [15:0] ram_address, ram_write_data, ram_read_data;
  logic [1:0]  owner;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .owner(owner)
  );

  always #5 clock = ~clock;

  // RAM model, reloaded with a known pattern while reset is high
  logic [15:0] mem [256];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
      mem[8'h10] <= 16'hBEEF;
    end else begin
      if (ram_write_enable) mem[ram_address[7:0]] <= ram_write_data;
      if (ram_read_enable) ram_read_data <= mem[ram_address[7:0]];
    end
  end

  typedef struct {
    logic        ar, aw;
    logic [15:0] aa, ad;
    logic        br, bw;
    logic [15:0] ba, bd;
    logic [1:0]  gnt;
    logic        re, we;
    logic [15:0] addr, wd;
    logic        arv;
    logic [15:0] ard;
    logic        brv;
    logic [15:0] brd;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [15:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [15:0] ba, input logic [15:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic both_read();
    drive(1'b1, 1'b0, 16'h0031, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0);
  endtask

  localparam vec_t V_IDLE_A = '{1'b0,1'b0,16'h0,16'h0, 1'b0,1'b0,16'h0,16'h0,
                                2'b00,1'b0,1'b0,16'h0,16'h0, 1'b1,16'hA031,1'b0,16'hA042};

  logic [1:0] exp_own [5];
  logic [1:0] exp_tie2;

  initial begin
    // Reset held with both requesting
    reset = 1'b1;
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("rst%0d gnt", c), {30'h0, b_gnt, a_gnt}, 32'h0);
      chk($sformatf("rst%0d en", c), {30'h0, ram_read_enable, ram_write_enable}, 32'h0);
      chk($sformatf("rst%0d rvalid", c), {30'h0, b_rvalid, a_rvalid}, 32'h0);
      chk($sformatf("rst%0d owner", c), {30'h0, owner}, 32'h0);
    end

    //          ar   aw   aa        ad        br   bw   ba        bd        gnt   re   we   addr      wd        arv  ard        brv  brd
    vecs[0]  = '{1'b1,1'b0,16'h0010,16'h0,    1'b0,1'b0,16'h0,    16'h0,    2'b01,1'b1,1'b0,16'h0010,16'h0,    1'b0,16'h0,    1'b0,16'h0};
    vecs[1]  = '{1'b0,1'b0,16'h0,   16'h0,    1'b0,1'b0,16'h0,    16'h0,    2'b00,1'b0,1'b0,16'h0,   16'h0,    1'b1,16'hBEEF, 1'b0,16'h0};
    vecs[2]  = '{1'b0,1'b0,16'h0,   16'h0,    1'b1,1'b1,16'h0020, 16'h1234, 2'b10,1'b0,1'b1,16'h0020,16'h1234, 1'b0,16'hBEEF, 1'b0,16'h0};
    vecs[3]  = '{1'b1,1'b0,16'h0020,16'h0,    1'b0,1'b0,16'h0,    16'h0,    2'b01,1'b1,1'b0,16'h0020,16'h0,    1'b0,16'hBEEF, 1'b0,16'h0};
    vecs[4]  = '{1'b0,1'b0,16'h0,   16'h0,    1'b0,1'b0,16'h0,    16'h0,    2'b00,1'b0,1'b0,16'h0,   16'h0,    1'b1,16'h1234, 1'b0,16'h0};
    vecs[5]  = '{1'b0,1'b0,16'h0,   16'h0,    1'b1,1'b0,16'h0042, 16'h0,    2'b10,1'b1,1'b0,16'h0042,16'h0,    1'b0,16'h1234, 1'b0,16'h0};
    vecs[6]  = '{1'b0,1'b0,16'h0,   16'h0,    1'b0,1'b0,16'h0,    16'h0,    2'b00,1'b0,1'b0,16'h0,   16'h0,    1'b0,16'h1234, 1'b1,16'hA042};
    vecs[7]  = '{1'b1,1'b0,16'h0031,16'h0,    1'b1,1'b0,16'h0042, 16'h0,    2'b01,1'b1,1'b0,16'h0031,16'h0,    1'b0,16'h1234, 1'b0,16'hA042};
    for (int i = 8; i <= 10; i++)
      vecs[i] = '{1'b1,1'b0,16'h0031,16'h0,   1'b1,1'b0,16'h0042, 16'h0,    2'b01,1'b1,1'b0,16'h0031,16'h0,    1'b1,16'hA031, 1'b0,16'hA042};
    vecs[11] = '{1'b1,1'b0,16'h0031,16'h0,    1'b1,1'b0,16'h0042, 16'h0,    2'b10,1'b1,1'b0,16'h0042,16'h0,    1'b1,16'hA031, 1'b0,16'hA042};
    for (int i = 12; i <= 14; i++)
      vecs[i] = '{1'b1,1'b0,16'h0031,16'h0,   1'b1,1'b0,16'h0042, 16'h0,    2'b10,1'b1,1'b0,16'h0042,16'h0,    1'b0,16'hA031, 1'b1,16'hA042};
    vecs[15] = '{1'b1,1'b0,16'h0031,16'h0,    1'b1,1'b0,16'h0042, 16'h0,    2'b01,1'b1,1'b0,16'h0031,16'h0,    1'b0,16'hA031, 1'b1,16'hA042};
    vecs[16] = V_IDLE_A;

    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) next_cycle();
      drive(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad, vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      @(negedge clock);
      chk($sformatf("v%0d gnt", i),    {30'h0, b_gnt, a_gnt}, {30'h0, vecs[i].gnt});
      chk($sformatf("v%0d owner", i),  {30'h0, owner}, {30'h0, vecs[i].gnt});
      chk($sformatf("v%0d en", i),     {30'h0, ram_read_enable, ram_write_enable}, {30'h0, vecs[i].re, vecs[i].we});
      chk($sformatf("v%0d addr", i),   {16'h0, ram_address}, {16'h0, vecs[i].addr});
      chk($sformatf("v%0d wdata", i),  {16'h0, ram_write_data}, {16'h0, vecs[i].wd});
      chk($sformatf("v%0d a_rv", i),   {31'h0, a_rvalid}, {31'h0, vecs[i].arv});
      chk($sformatf("v%0d a_rd", i),   {16'h0, a_rdata}, {16'h0, vecs[i].ard});
      chk($sformatf("v%0d b_rv", i),   {31'h0, b_rvalid}, {31'h0, vecs[i].brv});
      chk($sformatf("v%0d b_rd", i),   {16'h0, b_rdata}, {16'h0, vecs[i].brd});
    end

    // Reset lands the cycle after a granted B read: the return is dropped
    next_cycle(); reset = 1'b1; idle();
    @(negedge clock);
    next_cycle(); reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0042, 16'h0);
    @(negedge clock);
    chk("rstrd gnt", {31'h0, b_gnt}, 32'h1);
    next_cycle(); reset = 1'b1; idle();
    @(negedge clock);
    chk("rstrd b_rv_in_rst", {31'h0, b_rvalid}, 32'h0);
    chk("rstrd gnt_in_rst", {30'h0, b_gnt, a_gnt}, 32'h0);
    next_cycle(); reset = 1'b0; idle();
    @(negedge clock);
    chk("rstrd b_rv_after", {31'h0, b_rvalid}, 32'h0);
    chk("rstrd b_rd_after", {16'h0, b_rdata}, 32'h0);
    chk("rstrd owner_after", {30'h0, owner}, 32'h0);

    // Burst counter restarts from zero after reset: A gets a full burst first
    exp_own = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int c = 0; c < 5; c++) begin
      next_cycle(); both_read();
      @(negedge clock);
      chk($sformatf("postrst own%0d", c), {30'h0, owner}, {30'h0, exp_own[c]});
    end
    next_cycle(); idle();
    @(negedge clock);
    chk("postrst b_rv", {31'h0, b_rvalid}, 32'h1);
    chk("postrst b_rd", {16'h0, b_rdata}, 32'h0000A042);

    // IDLE tie twice with an idle gap
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_tie2 = 2'b10;
`else
    exp_tie2 = 2'b01;
`endif
    next_cycle(); reset = 1'b1; idle();
    @(negedge clock);
    next_cycle(); reset = 1'b0; both_read();
    @(negedge clock);
    chk("tie1 owner", {30'h0, owner}, 32'h1);
    next_cycle(); idle();
    @(negedge clock);
    chk("tie gap owner", {30'h0, owner}, 32'h0);
    next_cycle(); both_read();
    @(negedge clock);
    chk("tie2 owner", {30'h0, owner}, {30'h0, exp_tie2});
    next_cycle(); idle();
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
